// File: rtl/control_sequencer_if.sv
// ----------------------------------------------------------------------------
// control_sequencer_if
//   Bundles every non-clock/reset signal between the control sequencer, its
//   instruction memory and the datapath it steers.
//
//   master : the sequencer (drives PC and control words, reads flags/instr)
//   slave  : the environment (instruction memory + datapath)
//
//   run          fetch enable
//   instr_addr   PC presented to instruction memory
//   instr_data   instruction word: op[17:14] DA[13:12] AA[11:10] BA[9:8] imm[7:0]
//   V,C,N,Z      datapath flags
//   jumpAddress  datapath-supplied jump target
//   constant     immediate field
//   MB,RW,MD,MW  datapath / data-memory controls
//   DA,AA,BA     register selects
//   FS           ALU function select
//   halted       sequencer is in its HALTED state
//   illegal      sticky illegal-opcode flag
// ----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int size = 8
);
  logic            run;
  logic [size-1:0] instr_addr;
  logic [17:0]     instr_data;
  logic            V, C, N, Z;
  logic [size-1:0] jumpAddress;
  logic [size-1:0] constant;
  logic            MB, RW, MD, MW;
  logic [1:0]      DA, AA, BA;
  logic [3:0]      FS;
  logic            halted;
  logic            illegal;

  modport master (
    input  run, instr_data, V, C, N, Z, jumpAddress,
    output instr_addr, constant, MB, RW, MD, MW, DA, AA, BA, FS, halted, illegal
  );

  modport slave (
    output run, instr_data, V, C, N, Z, jumpAddress,
    input  instr_addr, constant, MB, RW, MD, MW, DA, AA, BA, FS, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Two-cycle (FETCH + EXEC) instruction sequencer for a small register-file
//   datapath. FETCH latches the instruction word into IR; EXEC decodes IR into
//   datapath controls, captures flags for flag-setting ops and advances PC.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears state, PC, IR, flags and
//            the illegal flag, so every output drops to 0 without a clock
//     bus    control_sequencer_if.master (see the interface for signals)
//
//   Build option:
//     ILLEGAL_TRAP_EN  when defined, opcodes A-E set the sticky illegal flag
//                      and halt with PC unchanged; when undefined they behave
//                      as NOP and illegal stays 0.
// ----------------------------------------------------------------------------
module control_sequencer #(
  parameter int         size     = 8,
  parameter logic [3:0] FS_ADD   = 4'b0010,
  parameter logic [3:0] FS_SUB   = 4'b0101,
  parameter logic [3:0] FS_PASSB = 4'b1100
) (
  input logic                 clk,
  input logic                 rst_n,
  control_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_ADDI = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_LDI  = 4'h5,
    OP_BRZ  = 4'h6,
    OP_BRN  = 4'h7,
    OP_JMP  = 4'h8,
    OP_CMP  = 4'h9,
    OP_HALT = 4'hF
  } op_t;

  state_t          state;
  logic [size-1:0] pc;
  logic [17:0]     ir;
  logic [3:0]      flags;     // {Vr, Cr, Nr, Zr}
  logic            illegal;

  logic [3:0]      op;
  logic [7:0]      imm;
  logic            updates_flags;
  logic [size-1:0] pc_inc;
  logic [size-1:0] pc_branch;

  assign op  = ir[17:14];
  assign imm = ir[7:0];

  assign updates_flags = (op == OP_ALU) || (op == OP_ADDI) || (op == OP_CMP);

  // Both sums wrap naturally at 2^size; the branch offset is the 8-bit
  // immediate sign-extended to the PC width.
  assign pc_inc    = pc + size'(1);
  assign pc_branch = pc + size'($signed(imm));

`ifdef ILLEGAL_TRAP_EN
  logic illegal_op;
  assign illegal_op = (op >= 4'hA) && (op <= 4'hE);
`endif

  // Vr and Cr are architectural state but no current branch tests them.
  logic unused_vc;
  assign unused_vc = ^flags[3:2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run) state <= FETCH;
        end
        FETCH: begin
          if (bus.run) begin
            ir    <= bus.instr_data;
            state <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          // run is deliberately ignored here: an instruction always completes.
          state <= FETCH;
          if (updates_flags) flags <= {bus.V, bus.C, bus.N, bus.Z};
          case (op)
            OP_BRZ:  pc <= flags[0] ? pc_branch : pc_inc;
            OP_BRN:  pc <= flags[1] ? pc_branch : pc_inc;
            OP_JMP:  pc <= bus.jumpAddress;
            OP_HALT: state <= HALTED;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              if (illegal_op) begin
                illegal <= 1'b1;
                state   <= HALTED;
              end else begin
                pc <= pc_inc;
              end
`else
              pc <= pc_inc;
`endif
            end
          endcase
        end
        HALTED: state <= HALTED;
      endcase
    end
  end

  assign bus.instr_addr = pc;
  assign bus.halted     = (state == HALTED);
  assign bus.illegal    = illegal;

  // Controls decode straight from IR during EXEC so RW/MW are single-cycle
  // pulses; reset forces state to IDLE, which zeroes them asynchronously.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.RW       = 1'b0;
    bus.MW       = 1'b0;
    bus.MB       = 1'b0;
    bus.MD       = 1'b0;
    bus.FS       = 4'b0000;
    bus.DA       = 2'b00;
    bus.AA       = 2'b00;
    bus.BA       = 2'b00;
    bus.constant = '0;
    if (state == EXEC) begin
      bus.DA       = ir[13:12];
      bus.AA       = ir[11:10];
      bus.BA       = ir[9:8];
      bus.constant = size'(imm);
      case (op)
        OP_ALU: begin
          bus.FS = imm[3:0];
          bus.RW = 1'b1;
        end
        OP_ADDI: begin
          bus.FS = FS_ADD;
          bus.MB = 1'b1;
          bus.RW = 1'b1;
        end
        OP_LD: begin
          bus.MD = 1'b1;
          bus.RW = 1'b1;
        end
        OP_ST: begin
          bus.MW = 1'b1;
        end
        OP_LDI: begin
          bus.FS = FS_PASSB;
          bus.MB = 1'b1;
          bus.RW = 1'b1;
        end
        OP_CMP: begin
          bus.FS = FS_SUB;
        end
        default: ;
      endcase
    end
  end

endmodule
